mac_rx: RTL and testbench
=========================

Name: mac_rx

Overview:
- RMII receive MAC, the receive-side counterpart of the team's RMII transmitter.
- Samples 2-bit rxd/crs_dv at the 50 MHz reference clock and locks onto the preamble and SFD.
- Assembles bytes, filters on destination MAC, extracts the source MAC and ethertype, and streams payload bytes with the 4-byte FCS stripped.
- Checks CRC-32 and frame length, and reports per-frame status; sits between the RMII PHY pins and the packet-processing logic.

Parameters:
- MAC, 48'h0, own station address; byte 0 is the first byte on the wire, packed in the same [0:5][3:0][1:0] order the transmitter uses.
- MIN_FRAME, 64, minimum legal frame length in bytes, dst through FCS.
- MAX_FRAME, 1518, maximum legal frame length in bytes, dst through FCS.

Ports:
- i_clk  in  1  RMII reference clock, 50 MHz.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_rxd  in  2  RMII receive dibit; LSB pair first within a byte.
- i_crs_dv  in  1  RMII carrier sense / data valid.
- o_valid  out  1  payload byte strobe, single cycle.
- o_data  out  8  payload byte; valid only with o_valid.
- o_sop  out  1  asserted together with o_valid on payload byte 0.
- o_eop  out  1  single-cycle end-of-frame strobe; never coincides with o_valid.
- o_status  out  3  qualified by o_eop: [0] CRC error, [1] length error, [2] alignment error.
- o_src_mac  out  48  source MAC of the current frame, same byte order as MAC.
- o_etype  out  16  {byte12, byte13}, i.e. network order, so it matches the transmitter's i_etype.
- o_drop  out  1  single-cycle pulse when a frame is discarded without ever issuing o_sop.
- o_busy  out  1  high from SFD detection until o_eop or o_drop.

Behaviour:
- Reset: one clock, i_rst_n asynchronous active-low. All outputs reset to 0. State goes to IDLE. CRC register is set to 32'hFFFFFFFF.
- State machine: IDLE, WAIT_LOW, PREAMBLE, HEADER, PAYLOAD, DROP.
- After reset release, or whenever i_crs_dv is already high, the block enters WAIT_LOW. WAIT_LOW moves to IDLE once i_crs_dv is sampled 0. The block never locks mid-frame.
- IDLE -> PREAMBLE when i_crs_dv=1 and i_rxd=01. In IDLE, dibit 00 with i_crs_dv=1 is ignored.
- PREAMBLE:
  - Counts consecutive 01 dibits.
  - Dibit 11 after 4 or more 01 dibits is the SFD: go to HEADER, clear the dibit and byte counters, set o_busy.
  - Any other pattern goes to DROP and pulses o_drop.
  - i_crs_dv=0 returns to IDLE silently.
- Byte assembly:
  - A 2-bit dibit index; dibit n fills byte bits [2n+1:2n].
  - The byte is complete on the cycle the 4th dibit is sampled.
  - An 11-bit byte counter counts dst through FCS and saturates at 2047.
- CRC:
  - Ethernet CRC-32, reflected polynomial 0xEDB88320, updated 2 bits per cycle over every dibit from dst through FCS.
  - No final inversion.
  - Frame is good iff the register equals 32'hDEBB20E3 after the last FCS dibit.
- HEADER:
  - Bytes 0-5 are compared against MAC and against FF:FF:FF:FF:FF:FF.
  - A mismatch detected at byte 5 goes to DROP and pulses o_drop.
  - Bytes 6-11 load o_src_mac and bytes 12-13 load o_etype. Both update together when byte 13 completes and hold until the next frame's byte 13.
  - i_crs_dv=0 before byte 13 pulses o_drop and returns to IDLE.
- PAYLOAD:
  - A 4-byte holdback shift register strips the FCS.
  - Received byte k (k>=14) is emitted on o_data when byte k+4 completes, with o_valid one cycle after completion.
  - The first emission carries o_sop. Bytes arrive one per 4 clocks, so o_valid is high at most every 4th cycle.
- End of frame:
  - Detected on the first cycle i_crs_dv is sampled 0 in PAYLOAD.
  - o_eop pulses the next cycle with o_status. The holdback contents (the FCS) are discarded.
  - If o_sop was never issued (total of 18 bytes or fewer), o_drop pulses instead of o_eop.
- Status bits:
  - [0] CRC residue mismatch.
  - [1] byte count < MIN_FRAME or > MAX_FRAME.
  - [2] dibit index != 0 when i_crs_dv fell. The partial byte is discarded and CRC is evaluated on the whole bytes received.
- Oversize frames:
  - When the byte count exceeds MAX_FRAME, payload emission stops, the state goes to DROP, and status [1] is latched.
  - o_eop with the latched status is issued when i_crs_dv falls.
- DROP: no outputs except the pending o_eop/o_drop. Returns to IDLE on i_crs_dv=0, and o_busy clears at the same time.
- Simultaneous events: i_crs_dv falling on the same cycle a byte completes means the byte is counted first, then end-of-frame is processed. Status bits may combine freely.
- Reset mid-frame: all outputs drop to 0 immediately, and the in-flight frame produces no o_eop or o_drop.

Optional Feature:
- Macro MAC_RX_PROMISC_EN.
- Defined: destination filtering is bypassed, every frame with a valid SFD is forwarded, and no o_drop pulses due to address.
- Undefined: only frames addressed to MAC or to broadcast are forwarded; others are dropped with an o_drop pulse.

Test Plan:
1. 64-byte frame to MAC, etype 0x0800, 46-byte payload 0x00..0x2D, correct FCS -> o_sop on byte 0x00, 46 o_valid pulses, o_eop with o_status=000, o_etype=16'h0800, o_src_mac matches the sender.
2. Same frame to FF:FF:FF:FF:FF:FF -> accepted and identical to case 1. Frame to 02:00:00:00:00:01 when MAC differs -> no o_valid, one o_drop pulse, o_busy falls when i_crs_dv falls. With MAC_RX_PROMISC_EN -> forwarded as in case 1.
3. Case 1 frame with FCS bit 0 flipped -> 46 payload bytes, then o_eop with o_status=001.
4. 60-byte frame including valid FCS -> 42 payload bytes, then o_eop with o_status=010. 1600-byte frame -> exactly 1500 payload bytes emitted, o_eop with o_status=010.
5. i_crs_dv dropped after 2 extra dibits past a valid 64-byte frame -> o_eop with o_status=100 and all 46 payload bytes delivered.
6. i_rst_n pulsed low at payload byte 20 while i_crs_dv stays high -> outputs 0 immediately, no o_eop, block stays in WAIT_LOW until i_crs_dv=0. The next clean frame is received correctly.

Source files
------------

// File: rtl/mac_rx.sv
// RMII receive MAC: preamble/SFD lock, dst filter, header extract,
// FCS-stripped payload stream, CRC-32/length/alignment status.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_rxd/i_crs_dv
// RMII pins; o_valid/o_data/o_sop payload stream; o_eop/o_status
// end-of-frame status {align,len,crc}; o_src_mac/o_etype header fields;
// o_drop discard pulse; o_busy frame in progress.
// Build option: MAC_RX_PROMISC_EN bypasses destination filtering.
module mac_rx #(
  parameter logic [47:0] MAC = 48'h0,
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_rxd,
  input  logic        i_crs_dv,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_sop,
  output logic        o_eop,
  output logic [2:0]  o_status,
  output logic [47:0] o_src_mac,
  output logic [15:0] o_etype,
  output logic        o_drop,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    IDLE, WAIT_LOW, PREAMBLE, HEADER, PAYLOAD, DROP
  } state_t;

  localparam logic [10:0] MIN_L = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_L = 11'(MAX_FRAME);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  state_t           state;
  logic             fresh;
  logic [2:0]       pre_cnt;
  logic [1:0]       idx;
  logic [7:0]       cur;
  logic [10:0]      bcnt;
  logic [31:0]      crc;
  logic [31:0]      crc_byte;
  logic             own_ok;
  logic             bc_ok;
  logic [47:0]      src_sh;
  logic [7:0]       et_hi;
  logic [3:0][7:0]  hold;
  logic             sop_done;
  logic             eop_pend;

  function automatic logic [31:0] crc2(
    input logic [31:0] c,
    input logic [1:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  logic        rx_on;
  logic        byte_done;
  logic [7:0]  byte_val;
  logic [31:0] crc_nx;
  logic [10:0] bcnt_nx;
  logic [7:0]  mac_b;
  logic        own_nx;
  logic        bc_nx;
  logic [2:0]  status;

  assign rx_on = (state == HEADER) || (state == PAYLOAD) ||
                 (state == DROP);
  assign byte_done = rx_on && i_crs_dv && (idx == 2'd3);
  assign byte_val = {i_rxd, cur[5:0]};
  assign crc_nx = crc2(crc, i_rxd);
  assign bcnt_nx = (bcnt == 11'h7FF) ? bcnt : bcnt + 11'd1;
  assign own_nx = own_ok && (byte_val == mac_b);
  assign bc_nx = bc_ok && (byte_val == 8'hFF);

  // CRC is judged on whole bytes only, so a trailing partial
  // byte does not disturb the residue check.
  assign status = {
    idx != 2'd0,
    (bcnt < MIN_L) || (bcnt > MAX_L),
    crc_byte != RESIDUE
  };

  always_comb begin
    case (bcnt[2:0])
      3'd0:    mac_b = MAC[47:40];
      3'd1:    mac_b = MAC[39:32];
      3'd2:    mac_b = MAC[31:24];
      3'd3:    mac_b = MAC[23:16];
      3'd4:    mac_b = MAC[15:8];
      3'd5:    mac_b = MAC[7:0];
      default: mac_b = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      fresh     <= 1'b0;
      pre_cnt   <= '0;
      idx       <= '0;
      cur       <= '0;
      bcnt      <= '0;
      crc       <= '1;
      crc_byte  <= '1;
      own_ok    <= 1'b0;
      bc_ok     <= 1'b0;
      src_sh    <= '0;
      et_hi     <= '0;
      hold      <= '0;
      sop_done  <= 1'b0;
      eop_pend  <= 1'b0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_sop     <= 1'b0;
      o_eop     <= 1'b0;
      o_status  <= '0;
      o_src_mac <= '0;
      o_etype   <= '0;
      o_drop    <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
      o_drop  <= 1'b0;

      if (rx_on && i_crs_dv) begin
        crc <= crc_nx;
        idx <= idx + 2'd1;
        cur[{idx, 1'b0} +: 2] <= i_rxd;
        if (idx == 2'd3) begin
          crc_byte <= crc_nx;
          bcnt     <= bcnt_nx;
        end
      end

      case (state)
        IDLE: begin
          fresh <= 1'b1;
          // Carrier already up, or mid-frame data: never lock.
          if (i_crs_dv) begin
            if (!fresh || i_rxd[1]) begin
              state <= WAIT_LOW;
            end else if (i_rxd == 2'b01) begin
              state   <= PREAMBLE;
              pre_cnt <= 3'd1;
            end
          end
        end

        WAIT_LOW: begin
          if (!i_crs_dv) state <= IDLE;
        end

        PREAMBLE: begin
          if (!i_crs_dv) begin
            state <= IDLE;
          end else if (i_rxd == 2'b01) begin
            if (pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
          end else if (i_rxd == 2'b11 && pre_cnt >= 3'd4) begin
            state    <= HEADER;
            o_busy   <= 1'b1;
            crc      <= '1;
            crc_byte <= '1;
            idx      <= '0;
            bcnt     <= '0;
            own_ok   <= 1'b1;
            bc_ok    <= 1'b1;
            sop_done <= 1'b0;
            eop_pend <= 1'b0;
          end else begin
            state  <= DROP;
            o_drop <= 1'b1;
          end
        end

        HEADER: begin
          if (!i_crs_dv) begin
            state  <= IDLE;
            o_drop <= 1'b1;
            o_busy <= 1'b0;
          end else if (byte_done) begin
            if (bcnt < 11'd6) begin
              own_ok <= own_nx;
              bc_ok  <= bc_nx;
            end
`ifdef MAC_RX_PROMISC_EN
`else
            if (bcnt == 11'd5 && !(own_nx || bc_nx)) begin
              state  <= DROP;
              o_drop <= 1'b1;
            end
`endif
            if (bcnt >= 11'd6 && bcnt < 11'd12)
              src_sh <= {src_sh[39:0], byte_val};
            if (bcnt == 11'd12)
              et_hi <= byte_val;
            if (bcnt == 11'd13) begin
              o_src_mac <= src_sh;
              o_etype   <= {et_hi, byte_val};
              state     <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (!i_crs_dv) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            if (sop_done) begin
              o_eop    <= 1'b1;
              o_status <= status;
            end else begin
              o_drop <= 1'b1;
            end
          end else if (byte_done) begin
            if (bcnt_nx > MAX_L) begin
              state    <= DROP;
              eop_pend <= 1'b1;
            end else begin
              // Four-byte holdback: the last four bytes are the FCS.
              hold <= {hold[2:0], byte_val};
              if (bcnt >= 11'd18) begin
                o_valid  <= 1'b1;
                o_data   <= hold[3];
                o_sop    <= !sop_done;
                sop_done <= 1'b1;
              end
            end
          end
        end

        DROP: begin
          if (!i_crs_dv) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            if (eop_pend) begin
              o_eop    <= 1'b1;
              o_status <= status;
              eop_pend <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx.sv
// Directed bench for mac_rx: table of frames with hand-computed
// expectations plus hand-written preamble/header corner sequences.
module tb_mac_rx;

  localparam logic [47:0] MYMAC = 48'h02_11_22_33_44_55;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_01;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [1:0]  i_rxd = 2'b00;
  logic        i_crs_dv = 1'b0;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_sop;
  logic        o_eop;
  logic [2:0]  o_status;
  logic [47:0] o_src_mac;
  logic [15:0] o_etype;
  logic        o_drop;
  logic        o_busy;

  always #10 i_clk = ~i_clk;

  mac_rx #(
    .MAC(MYMAC),
    .MIN_FRAME(64),
    .MAX_FRAME(1518)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_rxd(i_rxd),
    .i_crs_dv(i_crs_dv),
    .o_valid(o_valid),
    .o_data(o_data),
    .o_sop(o_sop),
    .o_eop(o_eop),
    .o_status(o_status),
    .o_src_mac(o_src_mac),
    .o_etype(o_etype),
    .o_drop(o_drop),
    .o_busy(o_busy)
  );

  logic [7:0] pay_q[$];
  int n_sop = 0;
  int n_eop = 0;
  int n_drop = 0;
  int sop_pos = -1;
  int viol = 0;
  logic [2:0] last_st = '0;

  always @(negedge i_clk) begin
    if (o_valid) begin
      pay_q.push_back(o_data);
      if (o_sop) sop_pos = pay_q.size() - 1;
    end
    if (o_sop) n_sop++;
    if (o_eop) begin
      n_eop++;
      last_st = o_status;
    end
    if (o_drop) n_drop++;
    if ((o_eop && o_valid) || (o_sop && !o_valid)) viol++;
  end

  int total = 0;
  int bad = 0;
  int cur_case = -1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s case=%0d got=%0h want=%0h",
               nm, cur_case, act, exp);
    end
  endtask

  task automatic dib(input logic dv, input logic [1:0] d);
    @(posedge i_clk);
    #1;
    i_crs_dv = dv;
    i_rxd = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) dib(1'b0, 2'b00);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) dib(1'b1, b[2*i +: 2]);
  endtask

  task automatic preamble();
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  function automatic logic [31:0] fcs_of(input logic [7:0] f[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (f[k])
      for (int b = 0; b < 8; b++)
        c = (c >> 1) ^ ((c[0] ^ f[k][b]) ? 32'hEDB88320 : 32'h0);
    return ~c;
  endfunction

  typedef struct {
    logic [47:0] dst;
    logic [15:0] et;
    int          plen;
    bit          badfcs;
    int          extra;
    int          rst_at;
    int          e_pay;
    int          e_eop;
    int          e_drop;
    logic [2:0]  e_st;
    bit          e_busy;
    bit          e_hdr;
  } vec_t;

  vec_t tv[11];

  task automatic run_vec(input int i);
    vec_t v;
    logic [7:0] f[$];
    logic [47:0] src;
    logic [31:0] fcs;
    logic b_end;
    logic b_aft;
    int p0, s0, e0, d0, n, pbad;
    v = tv[i];
    cur_case = i;
    src = 48'h02_A0_00_00_00_00 | 48'(i);
    for (int k = 0; k < 6; k++) f.push_back(v.dst[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) f.push_back(src[47-8*k -: 8]);
    f.push_back(v.et[15:8]);
    f.push_back(v.et[7:0]);
    for (int k = 0; k < v.plen; k++) f.push_back(8'(k));
    fcs = fcs_of(f);
    for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
    if (v.badfcs) f[f.size()-4] = f[f.size()-4] ^ 8'h01;
    p0 = pay_q.size();
    s0 = n_sop;
    e0 = n_eop;
    d0 = n_drop;
    preamble();
    for (int k = 0; k < f.size(); k++)
      for (int j = 0; j < 4; j++) begin
        if (k == v.rst_at && j == 2) begin
          @(posedge i_clk);
          #1;
          i_rst_n = 1'b0;
          #1;
          chk("rst_ctl", {o_valid, o_sop, o_eop, o_drop,
                          o_busy, o_status, o_data}, 64'd0);
          chk("rst_src", o_src_mac, 64'd0);
          chk("rst_et", o_etype, 64'd0);
        end
        dib(1'b1, f[k][2*j +: 2]);
        i_rst_n = 1'b1;
      end
    for (int e = 0; e < v.extra; e++) dib(1'b1, 2'b10);
    @(negedge i_clk);
    b_end = o_busy;
    dib(1'b0, 2'b00);
    idle(2);
    @(negedge i_clk);
    b_aft = o_busy;
    idle(10);
    n = pay_q.size() - p0;
    pbad = 0;
    for (int j = 0; j < n; j++)
      if (pay_q[p0+j] !== 8'(j)) pbad++;
    chk("pay_cnt", n, v.e_pay);
    chk("pay_data", pbad, 0);
    chk("sop_cnt", n_sop - s0, (v.e_pay > 0) ? 1 : 0);
    if (v.e_pay > 0) chk("sop_pos", sop_pos, p0);
    chk("eop_cnt", n_eop - e0, v.e_eop);
    chk("drop_cnt", n_drop - d0, v.e_drop);
    if (v.e_eop > 0) chk("status", last_st, v.e_st);
    if (v.e_hdr) begin
      chk("src_mac", o_src_mac, src);
      chk("etype", o_etype, v.et);
    end
    chk("busy_end", b_end, v.e_busy);
    chk("busy_aft", b_aft, 0);
  endtask

  initial begin
    int d0, e0, p0;
    tv[0]  = '{MYMAC, 16'h0800, 46,   1'b0, 0, -1,
               46,   1, 0, 3'b000, 1'b1, 1'b1};
    tv[1]  = '{BCAST, 16'h0800, 46,   1'b0, 0, -1,
               46,   1, 0, 3'b000, 1'b1, 1'b1};
`ifdef MAC_RX_PROMISC_EN
    tv[2]  = '{OTHER, 16'h0800, 46,   1'b0, 0, -1,
               46,   1, 0, 3'b000, 1'b1, 1'b1};
`else
    tv[2]  = '{OTHER, 16'h0800, 46,   1'b0, 0, -1,
               0,    0, 1, 3'b000, 1'b1, 1'b0};
`endif
    tv[3]  = '{MYMAC, 16'h0800, 46,   1'b1, 0, -1,
               46,   1, 0, 3'b001, 1'b1, 1'b1};
    tv[4]  = '{MYMAC, 16'h0800, 42,   1'b0, 0, -1,
               42,   1, 0, 3'b010, 1'b1, 1'b1};
    tv[5]  = '{MYMAC, 16'h0800, 1582, 1'b0, 0, -1,
               1500, 1, 0, 3'b010, 1'b1, 1'b1};
    tv[6]  = '{MYMAC, 16'h0800, 46,   1'b0, 2, -1,
               46,   1, 0, 3'b100, 1'b1, 1'b1};
    tv[7]  = '{MYMAC, 16'h0800, 46,   1'b0, 0, 34,
               16,   0, 0, 3'b000, 1'b0, 1'b0};
    tv[8]  = '{MYMAC, 16'h0800, 46,   1'b0, 0, -1,
               46,   1, 0, 3'b000, 1'b1, 1'b1};
    tv[9]  = '{MYMAC, 16'h86DD, 0,    1'b0, 0, -1,
               0,    0, 1, 3'b000, 1'b1, 1'b1};
    tv[10] = '{BCAST, 16'h0806, 1,    1'b0, 0, -1,
               1,    1, 0, 3'b010, 1'b1, 1'b1};

    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_ctl", {o_valid, o_sop, o_eop, o_drop,
                      o_busy, o_status, o_data}, 64'd0);
    chk("reset_src", o_src_mac, 64'd0);
    chk("reset_et", o_etype, 64'd0);
    i_rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 11; i++) run_vec(i);

    cur_case = 100;
    d0 = n_drop;
    e0 = n_eop;
    for (int i = 0; i < 3; i++) dib(1'b1, 2'b01);
    dib(1'b1, 2'b11);
    dib(1'b1, 2'b01);
    @(negedge i_clk);
    chk("short_pre_busy", o_busy, 0);
    for (int i = 0; i < 4; i++) dib(1'b1, 2'b01);
    idle(6);
    chk("short_pre_drop", n_drop - d0, 1);
    chk("short_pre_eop", n_eop - e0, 0);

    cur_case = 101;
    d0 = n_drop;
    for (int i = 0; i < 5; i++) dib(1'b1, 2'b01);
    dib(1'b1, 2'b10);
    for (int i = 0; i < 8; i++) dib(1'b1, 2'b01);
    idle(6);
    chk("bad_pre_drop", n_drop - d0, 1);

    cur_case = 102;
    d0 = n_drop;
    e0 = n_eop;
    p0 = pay_q.size();
    preamble();
    for (int i = 0; i < 10; i++) send_byte(8'hFF);
    @(negedge i_clk);
    chk("trunc_busy", o_busy, 1);
    idle(6);
    chk("trunc_drop", n_drop - d0, 1);
    chk("trunc_eop", n_eop - e0, 0);
    chk("trunc_pay", pay_q.size() - p0, 0);

    cur_case = 103;
    chk("protocol", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
